// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared state encoding and default sizing for the argmax controller
package argmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_CLASSES = 10;
  localparam int DEFAULT_IDX_WIDTH   = 4;

endpackage

// File: rtl/argmax_cmp.sv
// rtl/argmax_cmp.sv - single a >= b score comparator
// Signed compare when ARGMAX_SIGNED_EN is defined, unsigned otherwise.
module argmax_cmp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  ge
);

`ifdef ARGMAX_SIGNED_EN
  assign ge = $signed(a) >= $signed(b);
`else
  assign ge = a >= b;
`endif

endmodule

// File: rtl/argmax_stream_ctrl.sv
// rtl/argmax_stream_ctrl.sv - sequential argmax over a stream of class scores
// Compare signedness selected by ARGMAX_SIGNED_EN (see argmax_cmp).
module argmax_stream_ctrl
  import argmax_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
  parameter int IDX_WIDTH   = DEFAULT_IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_class,
  output logic [DATA_WIDTH-1:0] out_score,
  output logic                  busy,
  output logic                  err_len,
  input  logic                  err_clr
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                state;
  state_t                state_next;
  logic [IDX_WIDTH-1:0]  beat_cnt;
  logic [IDX_WIDTH-1:0]  beat_idx;
  logic [DATA_WIDTH-1:0] best_score;
  logic [DATA_WIDTH-1:0] best_score_next;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [IDX_WIDTH-1:0]  best_idx_next;
  logic                  accept;
  logic                  terminal;
  logic                  len_bad;
  logic                  score_ge;

  // The first beat of a frame is always index 0, whatever beat_cnt holds.
  assign beat_idx = (state == IDLE) ? '0 : beat_cnt;
  assign accept   = in_valid && in_ready;
  assign terminal = in_last || (beat_idx == LAST_IDX);
  assign len_bad  = !(in_last && (beat_idx == LAST_IDX));

  argmax_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .a  (in_data),
    .b  (best_score),
    .ge (score_ge)
  );

  // Running best including the beat on the bus; >= lets later ties win.
  always_comb begin
    best_score_next = best_score;
    best_idx_next   = best_idx;
    if (state == IDLE || score_ge) begin
      best_score_next = in_data;
      best_idx_next   = beat_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = terminal ? HOLD : ACCUM;
      ACCUM:   if (accept && terminal) state_next = HOLD;
      HOLD:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt   <= '0;
      best_score <= '0;
      best_idx   <= '0;
      out_score  <= '0;
      out_class  <= '0;
    end else if (accept) begin
      beat_cnt   <= beat_idx + 1'b1;
      best_score <= best_score_next;
      best_idx   <= best_idx_next;
      // Result registers only move at frame end so they hold after the handshake.
      if (terminal) begin
        out_score <= best_score_next;
        out_class <= best_idx_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_len <= 1'b0;
    end else if (accept && terminal && len_bad) begin
      err_len <= 1'b1;
    end else if (err_clr) begin
      err_len <= 1'b0;
    end
  end

endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// tb/tb_argmax_stream_ctrl.sv - self-checking bench for argmax_stream_ctrl
// Reference model follows ARGMAX_SIGNED_EN the same way as the design.
module tb_argmax_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_class;
  logic [31:0] out_score;
  logic        busy;
  logic        err_len;
  logic        err_clr;

  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          exp_err = 1'b0;
  logic [31:0] q[$];

  argmax_stream_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .busy      (busy),
    .err_len   (err_len),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit score_gt(input logic [31:0] a, input logic [31:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Winner = highest index holding the maximum value of the frame.
  function automatic void ref_argmax(input logic [31:0] s[$], output int cls, output logic [31:0] sc);
    sc = s[0];
    foreach (s[i]) if (score_gt(s[i], sc)) sc = s[i];
    cls = 0;
    foreach (s[i]) if (s[i] == sc) cls = i;
  endfunction

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic drive_beat(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] s[$], input bit use_last,
                           input int gap_pct, input int stall);
    int          cls;
    logic [31:0] sc;
    ref_argmax(s, cls, sc);
    if (!(use_last && s.size() == 10)) exp_err = 1'b1;
    foreach (s[i]) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      drive_beat(s[i], use_last && (i == s.size() - 1));
    end
    out_ready = (stall == 0);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " out_class"}, {28'd0, out_class}, cls);
    check({tag, " out_score"}, out_score, sc);
    check({tag, " err_len"}, {31'd0, err_len}, {31'd0, exp_err});
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < stall; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      in_last  = 1'b1;
      @(negedge clk);
      check({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " hold class"}, {28'd0, out_class}, cls);
      check({tag, " hold score"}, out_score, sc);
      check({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, " released"}, {31'd0, out_valid}, 32'd0);
    check({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    check({tag, " kept class"}, {28'd0, out_class}, cls);
    check({tag, " kept err"}, {31'd0, err_len}, {31'd0, exp_err});
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_clr", {31'd0, err_len}, 32'd0);
  endtask

  initial begin
    int          neg[10];
    int          short_s[5];
    int          len;
    bit          ul;
    logic [31:0] g[$];
    neg     = '{-5, -2, -9, -2, -7, -3, -4, -8, -6, -10};
    short_s = '{1, 2, 6, 4, 5};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_class", {28'd0, out_class}, 32'd0);
    check("rst out_score", out_score, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst err_len", {31'd0, err_len}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);

    q = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd1, 32'd0, 32'd2, 32'd7, 32'd8, 32'd4};
    run_frame("basic", q, 1'b1, 0, 0);

    q.delete();
    foreach (neg[i]) q.push_back(32'(neg[i]));
    run_frame("negative", q, 1'b1, 0, 0);

    q = '{32'd0, 32'hFFFF_FFFF, 32'd3};
    run_frame("sign", q, 1'b1, 0, 0);
    clear_err();

    q.delete();
    foreach (short_s[i]) q.push_back(32'(short_s[i]));
    run_frame("short", q, 1'b1, 0, 0);
    clear_err();

    q.delete();
    repeat (10) q.push_back($urandom);
    run_frame("forced", q, 1'b0, 0, 0);
    clear_err();

    // err_clr coinciding with an error event: the set must win
    err_clr = 1'b1;
    drive_beat(32'd7, 1'b1);
    err_clr = 1'b0;
    check("set wins", {31'd0, err_len}, 32'd1);
    check("one beat class", {28'd0, out_class}, 32'd0);
    @(negedge clk);
    clear_err();

    q.delete();
    repeat (10) q.push_back($urandom);
    run_frame("stall", q, 1'b1, 0, 20);
    q.delete();
    repeat (10) q.push_back($urandom_range(0, 15));
    run_frame("b2b", q, 1'b1, 0, 0);

    g.delete();
    for (int i = 0; i < 10; i++) g.push_back((i == 7) ? 32'd100 : 32'($urandom_range(0, 99)));
    run_frame("nogap", g, 1'b1, 0, 0);
    run_frame("gaps", g, 1'b1, 50, 0);

    for (int i = 0; i < 6; i++) drive_beat(32'd1000 + 32'(i), 1'b0);
    reset = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst out_class", {28'd0, out_class}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    q = '{32'd3, 32'd50, 32'd4, 32'd1, 32'd0, 32'd2, 32'd7, 32'd8, 32'd9, 32'd6};
    run_frame("after rst", q, 1'b1, 0, 0);

    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 10);
      ul  = (len < 10) ? 1'b1 : 1'($urandom_range(0, 1));
      q.delete();
      for (int i = 0; i < len; i++)
        q.push_back((f % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom);
      clear_err();
      run_frame("random", q, ul, 30, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
